fp_add_stream: RTL and testbench

Streaming handshake shell for the pipelined single-precision floating-point adder. Accepts operand pairs on a valid/ready interface, drives them into the adder, tracks each operation through the adder's fixed latency with a valid shift register, and captures results in an output FIFO so downstream backpressure never drops data. Sits directly between the operand producer and the adder, and consumes the adder's `result`.

---
 rtl/fp_add_stream.sv | 187 ++++++++++++++++++
 tb/tb_fp_add_stream.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_stream.sv
// ---------------------------------------------------------------------------
// fp_add_stream
//
// Valid/ready handshake wrapper for a pipelined single-precision adder with a
// fixed latency. Operand pairs are accepted from upstream and sent to the
// adder. A valid shift register follows each pair through the adder
// pipeline. Every sum is written into a small output FIFO, so downstream
// backpressure cannot lose a result. This block does no arithmetic. Results
// come out in the same order the pairs were accepted.
//
// Optional feature macro: FP_ADD_STREAM_GATE_EN
//   defined     : adder_a/adder_b carry the operands only on an accept cycle
//                 and are 32'h0 otherwise. This stops the adder toggling on
//                 idle or stalled cycles.
//   not defined : adder_a/adder_b follow in_a/in_b at all times. Sums from
//                 idle cycles are computed and then discarded through vld.
//
// Parameters
//   LATENCY     adder pipeline depth in cycles (1..4); must match the adder.
//   FIFO_DEPTH  output FIFO entries; power of two, >= 2.
//
// Ports
//   clk           clock; all state updates on the rising edge
//   reset         synchronous, active-high reset
//   in_valid      operand pair valid
//   in_ready      block can accept a pair this cycle
//   in_a, in_b    IEEE-754 single operands
//   adder_a/b     operands driven to the adder
//   adder_result  sum returned by the adder
//   out_valid     FIFO head valid
//   out_ready     downstream accepts the head
//   out_data      FIFO head sum
//   busy          an operation is in flight or buffered
// ---------------------------------------------------------------------------
module fp_add_stream #(
    parameter int LATENCY    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] adder_a,
    output logic [31:0] adder_b,
    input  logic [31:0] adder_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    // FIFO_DEPTH at the widths of the counters and of their sum.
    localparam logic [CW-1:0] DEPTH_CNT = FIFO_DEPTH[CW-1:0];
    localparam logic [CW:0]   DEPTH_OCC = FIFO_DEPTH[CW:0];

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [LATENCY-1:0] r_vld;
    logic [CW-1:0]      r_inflight;
    logic [CW-1:0]      r_count;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;

    // The FIFO is small and held in registers. This makes the head entry
    // visible in the same cycle it is written, with no read-latency slot.
    logic [31:0]        r_mem [FIFO_DEPTH];

    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [CW:0]        w_occupancy;

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    // Each accepted pair holds one credit from accept until it is popped:
    // first in inflight, then in r_count. Capping the total at FIFO_DEPTH
    // guarantees a free FIFO slot for every result the adder returns.
    // in_ready depends only on registered state, never on out_ready.
    assign w_occupancy = {1'b0, r_inflight} + {1'b0, r_count};
    assign in_ready    = (w_occupancy < DEPTH_OCC);
    assign w_accept    = in_valid && in_ready;
    assign w_push      = r_vld[LATENCY-1];
    assign w_pop       = out_valid && out_ready;

    assign out_valid   = (r_count != '0);
    assign out_data    = r_mem[r_rd_ptr];
    assign busy        = (r_inflight != '0) || (r_count != '0);

    // -----------------------------------------------------------------------
    // Adder operand drive
    // -----------------------------------------------------------------------
`ifdef FP_ADD_STREAM_GATE_EN
    assign adder_a = w_accept ? in_a : 32'h0;
    assign adder_b = w_accept ? in_b : 32'h0;
`else
    assign adder_a = in_a;
    assign adder_b = in_b;
`endif

    // -----------------------------------------------------------------------
    // Valid shift register: r_vld[i] means the pair accepted i+1 cycles ago
    // is still inside the adder.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld[0] <= 1'b0;
        end else begin
            r_vld[0] <= w_accept;
        end
    end

    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_vld
        always_ff @(posedge clk) begin
            if (reset) begin
                r_vld[gi] <= 1'b0;
            end else begin
                r_vld[gi] <= r_vld[gi-1];
            end
        end
    end

    // -----------------------------------------------------------------------
    // In-flight credit counter
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= '0;
        end else begin
            case ({w_accept, w_push})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers and occupancy. Pointers wrap naturally because
    // FIFO_DEPTH is a power of two. A push and a pop in the same cycle leave
    // the count unchanged. There is no bypass from push to pop.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage. Reset clears it so that out_data reads 0 out of reset.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            if (reset) begin
                r_mem[gi] <= 32'h0;
            end else if (w_push && (r_wr_ptr == AW'(gi))) begin
                r_mem[gi] <= adder_result;
            end
        end
    end

    // The credit rule makes a push into a full FIFO impossible.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(w_push && (r_count == DEPTH_CNT)));
        end
    end

endmodule

// File: tb/tb_fp_add_stream.sv
// ---------------------------------------------------------------------------
// tb_fp_add_stream
//
// Testbench for fp_add_stream with LATENCY=2 and FIFO_DEPTH=4. A behavioural
// adder pipeline with LATENCY register stages feeds adder_result. Each
// accepted pair pushes its expected sum into a scoreboard queue. Each pop
// compares out_data against the front entry of that queue.
// ---------------------------------------------------------------------------
module tb_fp_add_stream;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] adder_a;
    logic [31:0] adder_b;
    logic [31:0] adder_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] sb_q[$];
    logic        last_acc;
    int          acc_cnt;

    always #5 clk = ~clk;

    fp_add_stream #(
        .LATENCY   (LAT),
        .FIFO_DEPTH(DEPTH)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .adder_a     (adder_a),
        .adder_b     (adder_b),
        .adder_result(adder_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy)
    );

    // Float helpers. They are exact for the non-negative, integer-valued
    // operands used in this bench.
    function automatic int f2i(input logic [31:0] f);
        int e;
        int m;
        if (f[30:0] == 31'h0) return 0;
        e = int'(f[30:23]) - 127;
        if (e < 0) return 0;
        m = int'({8'h0, 1'b1, f[22:0]});
        return (e >= 23) ? (m << (e - 23)) : (m >> (23 - e));
    endfunction

    function automatic logic [31:0] i2f(input int n);
        int          p;
        logic [31:0] t;
        if (n <= 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 24; i++) if (n[i]) p = i;
        t = 32'(n) << (23 - p);
        return {1'b0, 8'(p + 127), t[22:0]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return i2f(f2i(a) + f2i(b));
    endfunction

    // Behavioural adder: LAT register stages.
    logic [31:0] add_pipe [LAT];
    always_ff @(posedge clk) begin
        add_pipe[0] <= fadd(adder_a, adder_b);
        for (int i = 1; i < LAT; i++) add_pipe[i] <= add_pipe[i-1];
    end
    assign adder_result = add_pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Inputs are applied at the falling edge. Outputs are
    // sampled 1 ns later, well before the next rising edge, where the DUT
    // commits the accept and pop seen here.
    task automatic cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #1;
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            sb_q.push_back(fadd(a, b));
            acc_cnt++;
        end
        if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_beat", out_data, 32'hxxxxxxxx);
            end else begin
                check("sb_data", out_data, sb_q.pop_front());
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((busy || sb_q.size() != 0) && n < budget) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b1);
            n++;
        end
        check("drain_done", {31'h0, busy}, 32'h0);
        check("drain_sb_empty", 32'(sb_q.size()), 32'h0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_a      = 32'h0;
        in_b      = 32'h0;
        out_ready = 1'b0;
        acc_cnt   = 0;
        last_acc  = 1'b0;

        // ---- reset values ----
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_out_data", out_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // ---- single op: 1.0 + 2.0, out_valid LAT+1 cycles after accept ----
        cycle(1'b1, 32'h3F800000, 32'h40000000, 1'b1);
        check("single_acc", {31'h0, last_acc}, 32'h1);
        for (int k = 1; k <= LAT; k++) begin
            cycle(1'b0, 32'h0, 32'h0, 1'b0);
            check("single_early_valid", {31'h0, out_valid}, 32'h0);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1);
        check("single_valid", {31'h0, out_valid}, 32'h1);
        check("single_data", out_data, 32'h40400000);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);
        check("single_one_beat", {31'h0, out_valid}, 32'h0);

        // ---- 8 back-to-back pairs k.0 + 1.0 at full throughput ----
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, i2f(k), 32'h3F800000, 1'b1);
            check("b2b_accept", {31'h0, last_acc}, 32'h1);
        end
        drain(20);

        // ---- backpressure: exactly DEPTH accepts ----
        acc_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, i2f(k + 10), 32'h40000000, 1'b0);
        end
        check("bp_accepts", 32'(acc_cnt), 32'(DEPTH));
        check("bp_in_ready", {31'h0, in_ready}, 32'h0);
        check("bp_busy", {31'h0, busy}, 32'h1);
        // First pop: in_ready must stay low in the pop cycle itself.
        cycle(1'b0, 32'h0, 32'h0, 1'b1);
        check("bp_ready_same_cycle", {31'h0, in_ready}, 32'h0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);
        check("bp_ready_after_pop", {31'h0, in_ready}, 32'h1);
        drain(20);

        // ---- alternating out_ready with continuous input ----
        for (int k = 0; k < 30; k++) begin
            cycle(1'b1, i2f(k + 1), i2f(k + 3), logic'(k[0]));
        end
        drain(40);

        // ---- reset with results buffered and in flight ----
        cycle(1'b1, i2f(5), i2f(6), 1'b0);
        cycle(1'b1, i2f(7), i2f(8), 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0);
        cycle(1'b1, i2f(9), i2f(1), 1'b0);
        cycle(1'b1, i2f(2), i2f(3), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
        #1;
        check("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
        for (int k = 0; k < LAT + 2; k++) begin
            cycle(1'b0, 32'h40A00000, 32'h0, 1'b1);
            check("post_rst_no_stale", {31'h0, out_valid}, 32'h0);
        end

        // ---- idle operand drive ----
        cycle(1'b0, 32'h40A00000, 32'h3F800000, 1'b1);
`ifdef FP_ADD_STREAM_GATE_EN
        check("idle_adder_a", adder_a, 32'h0);
`else
        check("idle_adder_a", adder_a, 32'h40A00000);
`endif
        check("idle_out_valid", {31'h0, out_valid}, 32'h0);
        cycle(1'b1, 32'h40A00000, 32'h3F800000, 1'b1);
        check("active_adder_a", adder_a, 32'h40A00000);
        drain(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
